// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: region encodings and 640x480@60 axis constants.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    REGION_ACTIVE = 2'd0,
    REGION_FRONT  = 2'd1,
    REGION_SYNC   = 2'd2,
    REGION_BACK   = 2'd3
  } region_t;

  localparam int H_ACTIVE_LEN = 640;
  localparam int H_FRONT_LEN  = 16;
  localparam int H_SYNC_LEN   = 96;
  localparam int H_BACK_LEN   = 48;

  localparam int V_ACTIVE_LEN = 480;
  localparam int V_FRONT_LEN  = 10;
  localparam int V_SYNC_LEN   = 2;
  localparam int V_BACK_LEN   = 33;

endpackage

// File: rtl/sync_timing_generator.sv
// Single-axis VGA timing generator: position counter, region FSM and registered
// sync/active/blank decode, with a combinational cascade tick for the next axis.
module sync_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_LEN       = 480,
  parameter int FRONT_LEN        = 10,
  parameter int SYNC_LEN         = 2,
  parameter int BACK_LEN         = 33,
  parameter bit SYNC_ACTIVE_HIGH = 1'b0,
  parameter int COUNTER_SIZE     = 11
) (
  input  logic                    control_clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    resync,
  output logic                    sync,
  output logic                    active,
  output logic                    blank,
  output logic [COUNTER_SIZE-1:0] position,
  output logic [1:0]              region,
  output logic                    wrap_tick
);

  localparam int TOTAL = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;

  generate
    if (TOTAL > (2 ** COUNTER_SIZE)) begin : g_size_check
      $error("sync_timing_generator: period does not fit in COUNTER_SIZE bits");
    end
  endgenerate

  // Last position of each region, held at counter width.
  localparam logic [COUNTER_SIZE-1:0] ACTIVE_END = COUNTER_SIZE'(ACTIVE_LEN - 1);
  localparam logic [COUNTER_SIZE-1:0] FRONT_END  = COUNTER_SIZE'(ACTIVE_LEN + FRONT_LEN - 1);
  localparam logic [COUNTER_SIZE-1:0] SYNC_END   = COUNTER_SIZE'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN - 1);
  localparam logic [COUNTER_SIZE-1:0] LAST_POS   = COUNTER_SIZE'(TOTAL - 1);
  localparam logic                    SYNC_ON    = SYNC_ACTIVE_HIGH;

  region_t                   region_q;
  region_t                   region_d;
  logic [COUNTER_SIZE-1:0]   pos_d;
  logic                      at_last;

  assign at_last   = (position == LAST_POS);
  assign wrap_tick = enable & ~resync & at_last;
  assign region    = region_q;

  always_comb begin
    pos_d    = position;
    region_d = region_q;
    if (resync) begin
      pos_d    = '0;
      region_d = REGION_ACTIVE;
    end else if (enable) begin
      pos_d = at_last ? '0 : position + 1'b1;
      case (region_q)
        REGION_ACTIVE: if (position == ACTIVE_END) region_d = REGION_FRONT;
        REGION_FRONT:  if (position == FRONT_END)  region_d = REGION_SYNC;
        REGION_SYNC:   if (position == SYNC_END)   region_d = REGION_BACK;
        REGION_BACK:   if (at_last)                region_d = REGION_ACTIVE;
        default:                                   region_d = REGION_ACTIVE;
      endcase
    end
  end

  // Flags decode from the next state so they move on the same edge as position.
  always_ff @(posedge control_clock) begin
    if (!reset_n) begin
      position <= '0;
      region_q <= REGION_ACTIVE;
      active   <= 1'b1;
      blank    <= 1'b0;
      sync     <= ~SYNC_ON;
    end else begin
      position <= pos_d;
      region_q <= region_d;
      active   <= (region_d == REGION_ACTIVE);
      blank    <= (region_d != REGION_ACTIVE);
      sync     <= (region_d == REGION_SYNC) ? SYNC_ON : ~SYNC_ON;
    end
  end

endmodule

// File: tb/tb_sync_timing_generator.sv
// Bench for sync_timing_generator: four instances (main, high-polarity, H->V cascade)
// checked every cycle against an arithmetic period model plus literal scenario checks.
module tb_sync_timing_generator;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic enable = 1'b0;
  logic resync = 1'b0;

  always #5 clk = ~clk;

  logic       m_sync, m_active, m_blank, m_wrap;
  logic [3:0] m_position;
  logic [1:0] m_region;
  logic       p_sync, p_active, p_blank, p_wrap;
  logic [3:0] p_position;
  logic [1:0] p_region;
  logic       h_sync, h_active, h_blank, h_wrap;
  logic [3:0] h_position;
  logic [1:0] h_region;
  logic       v_sync, v_active, v_blank, v_wrap;
  logic [3:0] v_position;
  logic [1:0] v_region;

  sync_timing_generator #(.ACTIVE_LEN(4), .FRONT_LEN(2), .SYNC_LEN(3), .BACK_LEN(1),
    .SYNC_ACTIVE_HIGH(1'b0), .COUNTER_SIZE(4)) u_main (
    .control_clock(clk), .reset_n(reset_n), .enable(enable), .resync(resync),
    .sync(m_sync), .active(m_active), .blank(m_blank), .position(m_position),
    .region(m_region), .wrap_tick(m_wrap));

  sync_timing_generator #(.ACTIVE_LEN(4), .FRONT_LEN(2), .SYNC_LEN(1), .BACK_LEN(3),
    .SYNC_ACTIVE_HIGH(1'b1), .COUNTER_SIZE(4)) u_hi (
    .control_clock(clk), .reset_n(reset_n), .enable(enable), .resync(resync),
    .sync(p_sync), .active(p_active), .blank(p_blank), .position(p_position),
    .region(p_region), .wrap_tick(p_wrap));

  sync_timing_generator #(.ACTIVE_LEN(4), .FRONT_LEN(1), .SYNC_LEN(1), .BACK_LEN(1),
    .SYNC_ACTIVE_HIGH(1'b0), .COUNTER_SIZE(4)) u_h (
    .control_clock(clk), .reset_n(reset_n), .enable(enable), .resync(resync),
    .sync(h_sync), .active(h_active), .blank(h_blank), .position(h_position),
    .region(h_region), .wrap_tick(h_wrap));

  sync_timing_generator #(.ACTIVE_LEN(2), .FRONT_LEN(1), .SYNC_LEN(1), .BACK_LEN(1),
    .SYNC_ACTIVE_HIGH(1'b0), .COUNTER_SIZE(4)) u_v (
    .control_clock(clk), .reset_n(reset_n), .enable(h_wrap), .resync(resync),
    .sync(v_sync), .active(v_active), .blank(v_blank), .position(v_position),
    .region(v_region), .wrap_tick(v_wrap));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: only a position per instance; everything else is derived from it.
  int  mp_main = 0, mp_hi = 0, mp_h = 0, mp_v = 0;
  bit  m_valid = 0;
  int  wc_main = 0, wc_h = 0, wc_v = 0;

  function automatic int region_of(input int pos, input int a, input int f, input int s);
    if (pos < a)         return 0;
    if (pos < a + f)     return 1;
    if (pos < a + f + s) return 2;
    return 3;
  endfunction

  always @(posedge clk) begin
    wc_main += int'(m_wrap);
    wc_h    += int'(h_wrap);
    wc_v    += int'(v_wrap);
    if (!reset_n) begin
      mp_main = 0; mp_hi = 0; mp_h = 0; mp_v = 0;
      m_valid = 1;
    end else if (resync) begin
      mp_main = 0; mp_hi = 0; mp_h = 0; mp_v = 0;
    end else if (enable) begin
      if (mp_h == 6) mp_v = (mp_v + 1) % 5;
      mp_main = (mp_main + 1) % 10;
      mp_hi   = (mp_hi + 1) % 10;
      mp_h    = (mp_h + 1) % 7;
    end
  end

  task automatic cmp_inst(input string nm, input int pos, input int reg_a, input logic act,
                          input logic blk, input logic syn, input logic wrp, input int mpos,
                          input int a, input int f, input int s, input int total,
                          input logic hi, input logic en);
    int er;
    er = region_of(mpos, a, f, s);
    chk({nm, ".position"}, pos, mpos);
    chk({nm, ".region"}, reg_a, er);
    chk({nm, ".active"}, int'(act), int'(er == 0));
    chk({nm, ".blank"}, int'(blk), int'(!act));
    chk({nm, ".sync"}, int'(syn), (er == 2) ? int'(hi) : int'(!hi));
    chk({nm, ".wrap_tick"}, int'(wrp), int'(en && !resync && mpos == total - 1));
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      cmp_inst("main", m_position, m_region, m_active, m_blank, m_sync, m_wrap, mp_main,
               4, 2, 3, 10, 1'b0, enable);
      cmp_inst("hi", p_position, p_region, p_active, p_blank, p_sync, p_wrap, mp_hi,
               4, 2, 1, 10, 1'b1, enable);
      cmp_inst("h", h_position, h_region, h_active, h_blank, h_sync, h_wrap, mp_h,
               4, 1, 1, 7, 1'b0, enable);
      cmp_inst("v", v_position, v_region, v_active, v_blank, v_sync, v_wrap, mp_v,
               2, 1, 1, 5, 1'b0, enable && !resync && mp_h == 6);
    end
  end

  task automatic step(input logic e, input logic r, input logic n);
    enable = e; resync = r; reset_n = n;
    @(posedge clk);
    #1;
  endtask

  int pos_seq  [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
  int reg_seq  [11] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 3, 0};
  int act_seq  [11] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
  int sync_seq [11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1};
  int hi_seq   [11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};

  initial begin
    int w0, h0, v0;
    // Reset state
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("reset.position", m_position, 0);
    chk("reset.region", m_region, 0);
    chk("reset.active", m_active, 1);
    chk("reset.blank", m_blank, 0);
    chk("reset.sync_low_pol", m_sync, 1);
    chk("reset.sync_high_pol", p_sync, 0);

    // One full period with enable held high
    w0 = wc_main;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("s1.position", m_position, pos_seq[i]);
      chk("s1.region", m_region, reg_seq[i]);
      chk("s1.active", m_active, act_seq[i]);
      chk("s1.sync", m_sync, sync_seq[i]);
      chk("s6.hi_sync", p_sync, hi_seq[i]);
      chk("s6.hi_blank", p_blank, 1 - int'(p_active));
    end
    chk("s1.wrap_count", wc_main - w0, 1);

    // Enable on alternate cycles: 20 cycles per period, one wrap
    w0 = wc_main;
    for (int c = 0; c < 20; c++) step(c % 2 == 0, 1'b0, 1'b1);
    chk("s2.wrap_count", wc_main - w0, 1);
    chk("s2.position", m_position, 0);

    // Resync inside SYNC
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1);
    chk("s3.pre_position", m_position, 7);
    chk("s3.pre_sync", m_sync, 0);
    step(1'b1, 1'b1, 1'b1);
    chk("s3.position", m_position, 0);
    chk("s3.region", m_region, 0);
    chk("s3.sync", m_sync, 1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b1);
    w0 = wc_main;
    step(1'b1, 1'b1, 1'b1);
    chk("s3.wrap_suppressed", wc_main - w0, 0);
    chk("s3.position_at_last", m_position, 0);

    // Reset beats resync and enable
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    chk("s4.pre_position", m_position, 5);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("s4.position", m_position, 0);
      chk("s4.active", m_active, 1);
      chk("s4.sync", m_sync, 1);
    end
    step(1'b0, 1'b0, 1'b1);
    chk("s4.released_hold", m_position, 0);

    // Cascade: V advances once per 7 H ticks and wraps after 35
    h0 = wc_h; v0 = wc_v;
    for (int k = 1; k <= 35; k++) begin
      step(1'b1, 1'b0, 1'b1);
      if (k == 6)  chk("s5.v_pos_k6", v_position, 0);
      if (k == 7)  chk("s5.v_pos_k7", v_position, 1);
      if (k == 14) chk("s5.v_pos_k14", v_position, 2);
      if (k == 28) chk("s5.v_pos_k28", v_position, 4);
    end
    chk("s5.v_position_end", v_position, 0);
    chk("s5.h_position_end", h_position, 0);
    chk("s5.h_wraps", wc_h - h0, 5);
    chk("s5.v_wraps", wc_v - v0, 1);

    // Randomised traffic, checked every cycle by the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3, $urandom_range(0, 99) >= 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
